// File: rtl/noc_ni_pkg.sv
// ---------------------------------------------------------------------------
// noc_ni_pkg
// Shared definitions for the MIPS network interface: flit geometry, flit
// type codes, TX/RX FSM state encodings and a head-flit builder.
// ---------------------------------------------------------------------------
package noc_ni_pkg;

    localparam int FLIT_W = 34;
    localparam int DATA_W = 32;
    localparam int NODE_W = 2;

    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_HEAD = 2'd1,
        T_TAIL = 2'd2
    } tx_state_t;

    typedef enum logic {
        R_HEAD = 1'b0,
        R_TAIL = 1'b1
    } rx_state_t;

    // HEAD flit: type in [33:32], src in [3:2], dest in [1:0], rest zero.
    function automatic logic [FLIT_W-1:0] mk_head(input logic [NODE_W-1:0] dest,
                                                  input logic [NODE_W-1:0] src);
        return {FLIT_HEAD, {(DATA_W-2*NODE_W){1'b0}}, src, dest};
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// ---------------------------------------------------------------------------
// ni_fifo
// Synchronous FIFO with occupancy counter and fall-through read port.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties FIFO)
//   i_push, i_wdata write request / data (ignored when full)
//   i_pop           read request (ignored when empty)
//   o_rdata         entry at the head (valid when !o_empty)
//   o_full, o_empty occupancy flags, derived from the current count
//   o_count         number of stored entries
// ---------------------------------------------------------------------------
module ni_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Flags come from the registered count, so a push on a full FIFO is
    // refused even if a pop happens in the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mips_net_iface.sv
// ---------------------------------------------------------------------------
// mips_net_iface
// Network interface for the MIPS core's NoC port. Core sends are queued in
// a TX FIFO and emitted as HEAD+TAIL packets to the router; inbound router
// packets are checked, reduced to their payload and queued in an RX FIFO
// that the core drains with proc_ready_in.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   proc_valid, dest_add, NI_in core send request, destination, payload
//   proc_ready_in               core accepts an inbound message
//   mips_ni                     inbound message pending
//   data_valid, wd_NI           one-cycle delivery strobe and payload
//   tx_full, tx_drop            TX FIFO full, sticky dropped-send flag
//   rx_err                      sticky malformed-inbound-sequence flag
//   out_flit/out_valid/out_ready   flit stream to router
//   in_flit/in_valid/in_ready      flit stream from router
// ---------------------------------------------------------------------------
module mips_net_iface
    import noc_ni_pkg::*;
#(
    parameter logic [NODE_W-1:0] NODE_ID    = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_valid,
    input  logic [NODE_W-1:0] dest_add,
    input  logic [DATA_W-1:0] NI_in,
    input  logic              proc_ready_in,
    output logic              mips_ni,
    output logic              data_valid,
    output logic [DATA_W-1:0] wd_NI,
    output logic              tx_full,
    output logic              tx_drop,
    output logic              rx_err,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready
);

    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int TX_W = NODE_W + DATA_W;

    // ------------------------------------------------------------------ TX
    tx_state_t         r_tx_state, w_tx_next;
    logic [TX_W-1:0]   w_tx_rdata;
    logic              w_tx_full, w_tx_empty;
    logic [CW-1:0]     w_tx_count;
    logic              w_tx_push, w_tx_pop;
    logic              r_tx_drop;

    assign w_tx_push = proc_valid && !w_tx_full;
    assign w_tx_pop  = (r_tx_state == T_TAIL) && out_ready;

    ni_fifo #(.W(TX_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_wdata ({dest_add, NI_in}),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_rdata),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_tx_drop  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            if (proc_valid && w_tx_full) r_tx_drop <= 1'b1;
        end
    end

    // The incoming push is folded into the "non-empty" decisions so a send
    // reaches the wire the cycle after proc_valid and packets stream at one
    // per two cycles. The flit is built from the FIFO head, which only moves
    // on the TAIL handshake, so it stays stable while the router stalls.
    always_comb begin
        w_tx_next = r_tx_state;
        out_valid = 1'b0;
        out_flit  = '0;
        case (r_tx_state)
            T_IDLE: begin
                if (!w_tx_empty || w_tx_push) w_tx_next = T_HEAD;
            end
            T_HEAD: begin
                out_valid = 1'b1;
                out_flit  = mk_head(w_tx_rdata[TX_W-1:DATA_W], NODE_ID);
                if (out_ready) w_tx_next = T_TAIL;
            end
            T_TAIL: begin
                out_valid = 1'b1;
                out_flit  = {FLIT_TAIL, w_tx_rdata[DATA_W-1:0]};
                if (out_ready)
                    w_tx_next = (w_tx_count > CW'(1) || w_tx_push) ? T_HEAD : T_IDLE;
            end
            default: w_tx_next = T_IDLE;
        endcase
    end

    assign tx_full = w_tx_full;
    assign tx_drop = r_tx_drop;

    // ------------------------------------------------------------------ RX
    rx_state_t         r_rx_state, w_rx_next;
    logic [DATA_W-1:0] w_rx_rdata;
    logic              w_rx_full, w_rx_empty;
    logic [CW-1:0]     w_rx_cnt_unused;
    logic              w_rx_push, w_rx_pop, w_rx_err_set;
    logic              w_in_acc;
    logic [1:0]        w_in_type;
    logic              r_rx_err;
    logic              r_data_valid;
    logic [DATA_W-1:0] r_wd_ni;

    assign w_in_type = in_flit[FLIT_W-1:DATA_W];
    // In R_TAIL the next flit may carry a payload, so back-pressure there
    // whenever the RX FIFO has no room.
    assign in_ready  = (r_rx_state == R_HEAD) ? 1'b1 : !w_rx_full;
    assign w_in_acc  = in_valid && in_ready;
    assign w_rx_pop  = !w_rx_empty && proc_ready_in;

    ni_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_wdata (in_flit[DATA_W-1:0]),
        .i_pop   (w_rx_pop),
        .o_rdata (w_rx_rdata),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_cnt_unused)
    );

    // A stray HEAD while waiting for a TAIL abandons the old packet and
    // starts a new one; an illegal type resynchronises on the next HEAD.
    always_comb begin
        w_rx_next    = r_rx_state;
        w_rx_push    = 1'b0;
        w_rx_err_set = 1'b0;
        case (r_rx_state)
            R_HEAD: begin
                if (w_in_acc) begin
                    if (w_in_type == FLIT_HEAD) w_rx_next    = R_TAIL;
                    else                        w_rx_err_set = 1'b1;
                end
            end
            R_TAIL: begin
                if (w_in_acc) begin
                    case (w_in_type)
                        FLIT_TAIL: begin
                            w_rx_push = 1'b1;
                            w_rx_next = R_HEAD;
                        end
                        FLIT_HEAD: w_rx_err_set = 1'b1;
                        default: begin
                            w_rx_err_set = 1'b1;
                            w_rx_next    = R_HEAD;
                        end
                    endcase
                end
            end
            default: w_rx_next = R_HEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= R_HEAD;
            r_rx_err     <= 1'b0;
            r_data_valid <= 1'b0;
            r_wd_ni      <= '0;
        end else begin
            r_rx_state   <= w_rx_next;
            r_data_valid <= w_rx_pop;
            if (w_rx_err_set) r_rx_err <= 1'b1;
            if (w_rx_pop)     r_wd_ni  <= w_rx_rdata;
        end
    end

    assign mips_ni    = !w_rx_empty;
    assign data_valid = r_data_valid;
    assign wd_NI      = r_wd_ni;
    assign rx_err     = r_rx_err;

endmodule

// File: doc/mips_net_iface.md
# mips_net_iface

Network-interface block that terminates the MIPS core's NoC port: it accepts 32-bit messages issued from the core's execute stage, packetizes them into two-flit packets for the local router, and depacketizes inbound router packets into a buffer the core drains through its NI read handshake. It sits between the MIPS pipeline (the message initiator) and the local router port, acting as the responder and packet source/sink for that interface.

## Interface
- NODE_ID, 0, 2-bit id of this node; inserted as source in head flits
- FIFO_DEPTH, 4, entries in each of TX and RX FIFOs; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- proc_valid  in  1  one-cycle send request from the core's EX stage
- dest_add  in  2  destination node for the send
- NI_in  in  32  message payload for the send
- proc_ready_in  in  1  core ready to take an inbound message
- mips_ni  out  1  inbound message pending (RX FIFO non-empty)
- data_valid  out  1  one-cycle strobe: wd_NI holds a delivered message
- wd_NI  out  32  delivered inbound payload
- tx_full  out  1  TX FIFO full
- tx_drop  out  1  sticky: a send was dropped (FIFO full)
- rx_err  out  1  sticky: malformed flit sequence received
- out_flit  out  34  flit to router
- out_valid  out  1  out_flit valid
- out_ready  in  1  router accepts out_flit
- in_flit  in  34  flit from router
- in_valid  in  1  in_flit valid
- in_ready  out  1  block accepts in_flit

## Operation
- Flit format: [33:32] type (2'b01 HEAD, 2'b10 TAIL, others illegal); HEAD [1:0] dest, [3:2] src, [31:4] zero; TAIL [31:0] payload.
- TX FIFO entry = {dest_add, NI_in}. Push on proc_valid when not full; if full, entry discarded and tx_drop set (cleared only by rst). Full is evaluated on current count: a push in the same cycle as a pop on a full FIFO is still dropped.
- TX FSM: T_IDLE → T_HEAD when FIFO non-empty. T_HEAD: out_valid=1, out_flit=HEAD{dest, NODE_ID}; on out_ready → T_TAIL. T_TAIL: out_valid=1, out_flit=TAIL{payload}; on out_ready pop FIFO, → T_HEAD if FIFO still non-empty after pop, else T_IDLE. out_flit held stable while out_valid && !out_ready.
- RX FSM: R_HEAD: in_ready=1; HEAD accepted → R_TAIL; TAIL or illegal type → drop, set rx_err, stay. R_TAIL: in_ready = !rx_full; TAIL accepted → push payload, → R_HEAD; HEAD or illegal type → set rx_err, new HEAD restarts (stay R_TAIL), illegal → R_HEAD.
- Delivery: when RX non-empty and proc_ready_in=1, pop; next cycle data_valid=1 and wd_NI=popped payload. wd_NI holds last value otherwise.
- Reset: FIFOs emptied, FSMs to T_IDLE/R_HEAD; in-flight packets discarded. All outputs 0 after reset (in_ready=1 from first post-reset cycle).

## Timing
- Send: proc_valid at cycle N → HEAD on out_flit at N+1; with out_ready held high, TAIL at N+2, next packet's HEAD at N+3. Max throughput one packet per 2 cycles.
- Receive: TAIL accepted at edge M → mips_ni=1 at M+1; proc_ready_in=1 in M+1 → data_valid/wd_NI at M+2.
- Back-to-back delivery: proc_ready_in held high drains one message per cycle.
- Simultaneous RX push and pop: both performed; count unchanged; mips_ni stays 1.
- FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

## Structure
- Package noc_ni_pkg: FLIT_W=34, DATA_W=32, NODE_W=2, FLIT_HEAD/FLIT_TAIL constants, TX/RX FSM state enums.
- One sub-module ni_fifo (parameterised width/depth, sync reset, push/pop/full/empty/count), instantiated for TX (34-bit) and RX (32-bit).

## Test plan
- NODE_ID=1, send dest_add=2, NI_in=32'hDEADBEEF, out_ready=1 → cycle+1 out_flit=34'h1_0000_0006, cycle+2 34'h2_DEADBEEF.
- Five sends back-to-back with out_ready=0 → 4 buffered, tx_full=1, tx_drop=1; release out_ready → exactly 4 packets in order.
- Inbound HEAD then TAIL 32'h12345678, proc_ready_in=0 → mips_ni=1, no data_valid; raise proc_ready_in → one data_valid pulse, wd_NI=32'h12345678, mips_ni=0.
- TAIL with no HEAD, then illegal type 2'b11 → both dropped, rx_err=1, RX FIFO empty.
- RX FIFO full, HEAD accepted → in_ready=0 in R_TAIL until core pops; then TAIL accepted.
- rst asserted between HEAD and TAIL on both directions → all outputs 0, FIFOs empty, next packet processed normally.
